// File: rtl/compress_pkg.sv
// compress_pkg: shared widths, state encoding and bit-count clamp for the line unpacker
package compress_pkg;
  localparam int CACHE_LINE_DEF = 128;
  localparam int WORD_SIZE_DEF = 64;
  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
  function automatic logic [7:0] clamp_bits(input logic [7:0] bits, input int cap);
    return (32'(bits) > cap) ? 8'(cap) : bits;
  endfunction
endpackage

// File: rtl/window_extractor.sv
// window_extractor: MSB-aligned WORD_SIZE window at ptr, bits at or past the valid count read as 0
import compress_pkg::*;
module window_extractor #(
  parameter int CACHE_LINE = CACHE_LINE_DEF,
  parameter int WORD_SIZE = WORD_SIZE_DEF
) (
  input  logic [CACHE_LINE-1:0] line,
  input  logic [7:0]            ptr,
  input  logic [7:0]            bits,
  output logic [WORD_SIZE-1:0]  window
);
  logic [CACHE_LINE-1:0] shifted;
  logic [7:0]            avail;
  logic [WORD_SIZE-1:0]  mask;
  always_comb begin
    shifted = line << ptr;
    avail = (bits > ptr) ? bits - ptr : 8'd0;
    mask = (32'(avail) >= WORD_SIZE) ? '1 : ~({WORD_SIZE{1'b1}} >> avail);
    window = shifted[CACHE_LINE-1 -: WORD_SIZE] & mask;
  end
endmodule

// File: rtl/line_unpacker.sv
// line_unpacker: holds one compressed line and feeds a bit window to a variable-length decoder
import compress_pkg::*;
module line_unpacker #(
  parameter int CACHE_LINE = CACHE_LINE_DEF,
  parameter int WORD_SIZE = WORD_SIZE_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_line_valid,
  output logic                  o_line_ready,
  input  logic [CACHE_LINE-1:0] i_line_data,
  input  logic [7:0]            i_line_bits,
  output logic [WORD_SIZE-1:0]  o_window,
  output logic                  o_window_valid,
  input  logic                  i_consume_valid,
  input  logic [6:0]            i_consume_len,
  output logic [7:0]            o_remaining,
  output logic [3:0]            o_word_count,
  output logic                  o_line_done,
  output logic                  o_overrun
);
  state_t                state_q, state_d;
  logic [CACHE_LINE-1:0] line_q, line_d;
  logic [7:0]            bits_q, bits_d, ptr_q, ptr_d, sum;
  logic [3:0]            wc_q, wc_d;
  logic                  ovr_q, ovr_d, load, take;
  always_comb begin
    load = state_q == IDLE && i_line_valid;
    take = state_q == ACTIVE && i_consume_valid && i_consume_len != 7'd0;
    sum = ptr_q + {1'b0, i_consume_len};
    state_d = state_q;
    line_d = line_q;
    bits_d = bits_q;
    ptr_d = ptr_q;
    wc_d = wc_q;
    ovr_d = ovr_q;
    if (load) begin
      line_d = i_line_data;
      bits_d = clamp_bits(i_line_bits, CACHE_LINE);
      ptr_d = 8'd0;
      wc_d = 4'd0;
      ovr_d = 1'b0;
      state_d = (bits_d == 8'd0) ? DONE : ACTIVE;
    end else if (take) begin
      // a code running past the end pins ptr at bits so remaining reads 0
      ptr_d = (sum >= bits_q) ? bits_q : sum;
      wc_d = (wc_q == 4'hF) ? wc_q : wc_q + 4'd1;
      ovr_d = sum > bits_q;
      state_d = (sum >= bits_q) ? DONE : ACTIVE;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      line_q <= '0;
      bits_q <= 8'd0;
      ptr_q <= 8'd0;
      wc_q <= 4'd0;
      ovr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q <= line_d;
      bits_q <= bits_d;
      ptr_q <= ptr_d;
      wc_q <= wc_d;
      ovr_q <= ovr_d;
    end
  end
  window_extractor #(.CACHE_LINE(CACHE_LINE), .WORD_SIZE(WORD_SIZE)) u_win (
    .line(line_q),
    .ptr(ptr_q),
    .bits(bits_q),
    .window(o_window)
  );
  assign o_line_ready = state_q == IDLE;
  assign o_window_valid = state_q == ACTIVE;
  assign o_line_done = state_q == DONE;
  assign o_remaining = (state_q == IDLE) ? 8'd0 : bits_q - ptr_q;
  assign o_word_count = wc_q;
  assign o_overrun = ovr_q;
endmodule

// File: tb/tb_line_unpacker.sv
// tb_line_unpacker: directed scenarios with hand-computed expectations for line_unpacker
module tb_line_unpacker;
  logic         i_clk = 0, i_reset = 1, i_line_valid = 0, i_consume_valid = 0;
  logic [127:0] i_line_data = '0;
  logic [7:0]   i_line_bits = '0;
  logic [6:0]   i_consume_len = '0;
  logic         o_line_ready, o_window_valid, o_line_done, o_overrun;
  logic [63:0]  o_window;
  logic [7:0]   o_remaining;
  logic [3:0]   o_word_count;
  int n_tests = 0, n_fail = 0;
  localparam logic [127:0] PAT = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [127:0] F000 = {4'hF, 124'd0};

  line_unpacker dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_line_valid(i_line_valid), .o_line_ready(o_line_ready),
    .i_line_data(i_line_data), .i_line_bits(i_line_bits), .o_window(o_window),
    .o_window_valid(o_window_valid), .i_consume_valid(i_consume_valid), .i_consume_len(i_consume_len),
    .o_remaining(o_remaining), .o_word_count(o_word_count), .o_line_done(o_line_done), .o_overrun(o_overrun)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic load(input logic [127:0] d, input logic [7:0] b);
    i_line_valid = 1; i_line_data = d; i_line_bits = b;
    tick();
    i_line_valid = 0;
  endtask

  task automatic consume(input logic [6:0] len);
    i_consume_valid = 1; i_consume_len = len;
    tick();
    i_consume_valid = 0;
  endtask

  task automatic test_reset;
    #2;
    n_tests++; if (o_line_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", o_line_ready); end
    n_tests++; if (o_window_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wvalid got %b exp 0", o_window_valid); end
    n_tests++; if (o_remaining !== 8'd0) begin n_fail++; $display("FAIL reset_remaining got %0d exp 0", o_remaining); end
    n_tests++; if ({o_line_done, o_overrun, o_word_count} !== 6'd0) begin n_fail++; $display("FAIL reset_flags got %b exp 0", {o_line_done, o_overrun, o_word_count}); end
    n_tests++; if (o_window !== 64'd0) begin n_fail++; $display("FAIL reset_window got %h exp 0", o_window); end
    tick();
    i_reset = 0;
    tick();
  endtask

  task automatic test_basic;
    load(F000, 8'd128);
    n_tests++; if (o_window !== 64'hF000_0000_0000_0000) begin n_fail++; $display("FAIL basic_win0 got %h exp f000000000000000", o_window); end
    n_tests++; if (o_window_valid !== 1'b1 || o_line_ready !== 1'b0) begin n_fail++; $display("FAIL basic_state got v=%b r=%b exp v=1 r=0", o_window_valid, o_line_ready); end
    n_tests++; if (o_remaining !== 8'd128) begin n_fail++; $display("FAIL basic_rem0 got %0d exp 128", o_remaining); end
    consume(7'd4);
    n_tests++; if (o_window !== 64'd0) begin n_fail++; $display("FAIL basic_win1 got %h exp 0", o_window); end
    n_tests++; if (o_remaining !== 8'd124) begin n_fail++; $display("FAIL basic_rem1 got %0d exp 124", o_remaining); end
    n_tests++; if (o_word_count !== 4'd1) begin n_fail++; $display("FAIL basic_wc got %0d exp 1", o_word_count); end
    consume(7'd64);
    consume(7'd60);
    n_tests++; if (o_line_done !== 1'b1 || o_word_count !== 4'd3) begin n_fail++; $display("FAIL basic_done got d=%b wc=%0d exp d=1 wc=3", o_line_done, o_word_count); end
    tick();
  endtask

  task automatic test_window_pattern;
    load(PAT, 8'd128);
    n_tests++; if (o_window !== 64'h0123456789ABCDEF) begin n_fail++; $display("FAIL pat_win0 got %h exp 0123456789abcdef", o_window); end
    consume(7'd8);
    n_tests++; if (o_window !== 64'h23456789ABCDEFFE) begin n_fail++; $display("FAIL pat_win1 got %h exp 23456789abcdeffe", o_window); end
    consume(7'd60);
    n_tests++; if (o_window !== 64'hEDCBA98765432100) begin n_fail++; $display("FAIL pat_win2 got %h exp edcba98765432100", o_window); end
    n_tests++; if (o_remaining !== 8'd60) begin n_fail++; $display("FAIL pat_rem got %0d exp 60", o_remaining); end
    consume(7'd60);
    tick();
    load(PAT, 8'd12);
    n_tests++; if (o_window !== 64'h0120_0000_0000_0000) begin n_fail++; $display("FAIL pat_mask got %h exp 0120000000000000", o_window); end
    consume(7'd12);
    n_tests++; if (o_line_done !== 1'b1 || o_overrun !== 1'b0) begin n_fail++; $display("FAIL pat_exact got d=%b o=%b exp d=1 o=0", o_line_done, o_overrun); end
    tick();
  endtask

  task automatic test_three_codes;
    load('1, 8'd40);
    n_tests++; if (o_window !== 64'hFFFF_FFFF_FF00_0000) begin n_fail++; $display("FAIL t3_win0 got %h exp ffffffffff000000", o_window); end
    consume(7'd8);
    n_tests++; if (o_window !== 64'hFFFF_FFFF_0000_0000 || o_remaining !== 8'd32) begin n_fail++; $display("FAIL t3_step1 got %h/%0d exp ffffffff00000000/32", o_window, o_remaining); end
    consume(7'd16);
    n_tests++; if (o_window !== 64'hFFFF_0000_0000_0000 || o_remaining !== 8'd16) begin n_fail++; $display("FAIL t3_step2 got %h/%0d exp ffff000000000000/16", o_window, o_remaining); end
    n_tests++; if (o_line_done !== 1'b0) begin n_fail++; $display("FAIL t3_early_done got %b exp 0", o_line_done); end
    consume(7'd16);
    n_tests++; if (o_line_done !== 1'b1 || o_overrun !== 1'b0 || o_word_count !== 4'd3) begin n_fail++; $display("FAIL t3_done got d=%b o=%b wc=%0d exp 1 0 3", o_line_done, o_overrun, o_word_count); end
    n_tests++; if (o_window_valid !== 1'b0 || o_remaining !== 8'd0) begin n_fail++; $display("FAIL t3_done_win got v=%b r=%0d exp 0 0", o_window_valid, o_remaining); end
    tick();
    n_tests++; if (o_line_ready !== 1'b1 || o_line_done !== 1'b0 || o_word_count !== 4'd3) begin n_fail++; $display("FAIL t3_idle got r=%b d=%b wc=%0d exp 1 0 3", o_line_ready, o_line_done, o_word_count); end
  endtask

  task automatic test_overrun;
    load('1, 8'd20);
    consume(7'd32);
    n_tests++; if (o_overrun !== 1'b1 || o_line_done !== 1'b1 || o_remaining !== 8'd0) begin n_fail++; $display("FAIL ovr_set got o=%b d=%b r=%0d exp 1 1 0", o_overrun, o_line_done, o_remaining); end
    tick();
    n_tests++; if (o_overrun !== 1'b1 || o_line_ready !== 1'b1) begin n_fail++; $display("FAIL ovr_hold got o=%b r=%b exp 1 1", o_overrun, o_line_ready); end
    tick();
    n_tests++; if (o_overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_hold2 got %b exp 1", o_overrun); end
    load('1, 8'd8);
    n_tests++; if (o_overrun !== 1'b0 || o_word_count !== 4'd0) begin n_fail++; $display("FAIL ovr_clear got o=%b wc=%0d exp 0 0", o_overrun, o_word_count); end
    consume(7'd8);
    tick();
  endtask

  task automatic test_zero_bits;
    load('1, 8'd0);
    n_tests++; if (o_window_valid !== 1'b0 || o_line_done !== 1'b1) begin n_fail++; $display("FAIL zero_done got v=%b d=%b exp 0 1", o_window_valid, o_line_done); end
    tick();
    n_tests++; if (o_window_valid !== 1'b0 || o_line_done !== 1'b0 || o_line_ready !== 1'b1) begin n_fail++; $display("FAIL zero_idle got v=%b d=%b r=%b exp 0 0 1", o_window_valid, o_line_done, o_line_ready); end
  endtask

  task automatic test_ignore;
    load(PAT, 8'd16);
    consume(7'd0);
    n_tests++; if (o_remaining !== 8'd16 || o_word_count !== 4'd0) begin n_fail++; $display("FAIL ign_len0 got r=%0d wc=%0d exp 16 0", o_remaining, o_word_count); end
    i_line_valid = 1; i_line_data = F000; i_line_bits = 8'd100;
    tick();
    i_line_valid = 0;
    n_tests++; if (o_remaining !== 8'd16 || o_window !== 64'h0123_0000_0000_0000) begin n_fail++; $display("FAIL ign_load got r=%0d w=%h exp 16 0123000000000000", o_remaining, o_window); end
    consume(7'd16);
    tick();
  endtask

  task automatic test_saturate;
    load('1, 8'd128);
    for (int i = 0; i < 16; i++) consume(7'd1);
    n_tests++; if (o_word_count !== 4'd15 || o_remaining !== 8'd112) begin n_fail++; $display("FAIL sat got wc=%0d r=%0d exp 15 112", o_word_count, o_remaining); end
    consume(7'd64);
    consume(7'd48);
    n_tests++; if (o_line_done !== 1'b1 || o_word_count !== 4'd15) begin n_fail++; $display("FAIL sat_done got d=%b wc=%0d exp 1 15", o_line_done, o_word_count); end
    tick();
  endtask

  task automatic test_mid_reset;
    load('1, 8'd128);
    consume(7'd64);
    n_tests++; if (o_remaining !== 8'd64 || o_window !== '1) begin n_fail++; $display("FAIL mr_pre got r=%0d w=%h exp 64 ffffffffffffffff", o_remaining, o_window); end
    i_reset = 1;
    #1;
    n_tests++; if (o_line_ready !== 1'b1 || o_window_valid !== 1'b0 || o_remaining !== 8'd0 || o_window !== 64'd0 || o_word_count !== 4'd0) begin n_fail++; $display("FAIL mr_async got r=%b v=%b rem=%0d w=%h wc=%0d exp 1 0 0 0 0", o_line_ready, o_window_valid, o_remaining, o_window, o_word_count); end
    tick();
    i_reset = 0;
    tick();
    n_tests++; if (o_line_done !== 1'b0 || o_line_ready !== 1'b1) begin n_fail++; $display("FAIL mr_after got d=%b r=%b exp 0 1", o_line_done, o_line_ready); end
    load(F000, 8'd128);
    n_tests++; if (o_window !== 64'hF000_0000_0000_0000 || o_remaining !== 8'd128) begin n_fail++; $display("FAIL mr_reload got w=%h r=%0d exp f000000000000000 128", o_window, o_remaining); end
    consume(7'd64);
    consume(7'd64);
    tick();
  endtask

  task automatic test_clamp;
    load(PAT, 8'd200);
    n_tests++; if (o_remaining !== 8'd128) begin n_fail++; $display("FAIL clamp_bits got %0d exp 128", o_remaining); end
    consume(7'd64);
    n_tests++; if (o_remaining !== 8'd64 || o_window !== 64'hFEDCBA9876543210 || o_line_done !== 1'b0) begin n_fail++; $display("FAIL clamp_mid got r=%0d w=%h d=%b exp 64 fedcba9876543210 0", o_remaining, o_window, o_line_done); end
    consume(7'd64);
    n_tests++; if (o_line_done !== 1'b1 || o_overrun !== 1'b0) begin n_fail++; $display("FAIL clamp_done got d=%b o=%b exp 1 0", o_line_done, o_overrun); end
    tick();
  endtask

  task automatic test_back_to_back;
    i_line_valid = 1; i_line_data = PAT; i_line_bits = 8'd8;
    tick();
    n_tests++; if (o_window_valid !== 1'b1 || o_window !== 64'h0100_0000_0000_0000) begin n_fail++; $display("FAIL b2b_load1 got v=%b w=%h exp 1 0100000000000000", o_window_valid, o_window); end
    consume(7'd8);
    n_tests++; if (o_line_done !== 1'b1) begin n_fail++; $display("FAIL b2b_done got %b exp 1", o_line_done); end
    tick();
    n_tests++; if (o_line_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got %b exp 1", o_line_ready); end
    tick();
    i_line_valid = 0;
    n_tests++; if (o_window_valid !== 1'b1 || o_remaining !== 8'd8 || o_word_count !== 4'd0) begin n_fail++; $display("FAIL b2b_load2 got v=%b r=%0d wc=%0d exp 1 8 0", o_window_valid, o_remaining, o_word_count); end
    consume(7'd8);
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_window_pattern();
    test_three_codes();
    test_overrun();
    test_zero_bits();
    test_ignore();
    test_saturate();
    test_mid_reset();
    test_clamp();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/line_unpacker.md
LINE_UNPACKER -- requirements
Module: line_unpacker

Interface
REQ-001 SHALL have parameter CACHE_LINE, default 128, compressed line width in bits.
REQ-002 SHALL have parameter WORD_SIZE, default 64, extraction window width in bits.
REQ-003 SHALL have port i_clk, input, 1, single clock; all state on rising edge.
REQ-004 SHALL have port i_reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port i_line_valid, input, 1, compressed line offered.
REQ-006 SHALL have port o_line_ready, output, 1, unpacker can accept a line.
REQ-007 SHALL have port i_line_data, input, CACHE_LINE, compressed bits, first code at MSB.
REQ-008 SHALL have port i_line_bits, input, 8, number of valid compressed bits in line.
REQ-009 SHALL have port o_window, output, WORD_SIZE, next WORD_SIZE bits from read pointer, MSB-aligned.
REQ-010 SHALL have port o_window_valid, output, 1, window holds at least one unconsumed bit.
REQ-011 SHALL have port i_consume_valid, input, 1, downstream decoder consumed a code.
REQ-012 SHALL have port i_consume_len, input, 7, length of consumed code, 1..64.
REQ-013 SHALL have port o_remaining, output, 8, valid bits not yet consumed.
REQ-014 SHALL have port o_word_count, output, 4, codes consumed in current line, saturating at 15.
REQ-015 SHALL have port o_line_done, output, 1, one-cycle pulse when line fully consumed.
REQ-016 SHALL have port o_overrun, output, 1, sticky: a consume exceeded remaining bits.

Function
REQ-017 SHALL implement states IDLE, ACTIVE, DONE.
REQ-018 SHALL assert o_line_ready only in IDLE; load occurs on edge with i_line_valid and o_line_ready both high.
REQ-019 On load SHALL register line, set bits = min(i_line_bits, CACHE_LINE), ptr = 0, word_count = 0, clear o_overrun, go ACTIVE; if clamped bits = 0, go DONE instead.
REQ-020 SHALL drive o_window combinationally from registers: bit k = line[CACHE_LINE-1-ptr-k] when ptr+k < bits, else 0.
REQ-021 SHALL assert o_window_valid exactly when state is ACTIVE; first valid window appears the cycle after load.
REQ-022 SHALL ignore i_consume_valid unless o_window_valid is high; i_consume_len = 0 SHALL be a no-op.
REQ-023 On accepted consume SHALL set ptr = ptr + i_consume_len (8-bit, no wrap: max 128+64 < 256) and increment word_count saturating at 15; updated window visible next cycle.
REQ-024 When ptr + len == bits SHALL go DONE.
REQ-025 When ptr + len > bits SHALL clamp ptr to bits, set o_overrun, go DONE.
REQ-026 SHALL drive o_remaining = bits - ptr, 0 in IDLE.
REQ-027 DONE SHALL last exactly one cycle with o_line_done = 1, then return to IDLE; o_overrun, o_word_count hold until next load.
REQ-028 i_line_valid outside IDLE SHALL be ignored; the source holds it until o_line_ready.
REQ-029 Back-to-back throughput SHALL be one line per (consumes + 2) cycles minimum.

Reset
REQ-030 i_reset high SHALL asynchronously force IDLE, ptr = 0, bits = 0, line = 0, word_count = 0, o_overrun = 0, o_line_done = 0.
REQ-031 Mid-line reset SHALL discard the line with no o_line_done pulse; o_line_ready = 1 the first cycle after reset deasserts.

Structure
REQ-032 CACHE_LINE, WORD_SIZE defaults and the state enum SHALL live in shared package compress_pkg.
REQ-033 Window extraction SHALL be a combinational sub-module window_extractor (line, ptr, bits -> window).

Verification
REQ-034 Load 0xF000..0 (bits=128), consume 4 -> window next cycle 0x0000_0000_0000_0000, o_remaining 124, word_count 1.
REQ-035 bits=40, consumes 8,16,16 -> o_line_done on cycle after third consume, o_overrun 0, word_count 3, o_line_ready next cycle.
REQ-036 bits=20, consume 32 -> o_overrun 1, o_line_done pulse, o_remaining 0, overrun held until next load.
REQ-037 i_line_bits=0 -> o_window_valid never high, o_line_done pulse the cycle after load.
REQ-038 bits=128, consume 64 then assert i_reset -> IDLE, outputs zero, no o_line_done; next line loads normally.
REQ-039 i_line_bits=200, 2 consumes of 64 -> clamped to 128, done after second, o_overrun 0.
